tiny_eth_rx_deser: RTL

First stage of the tiny_eth receive path. Samples the serial line on `rx_clk`, finds the preamble and SFD, and turns the following bits into an LSB-first byte stream. It marks the start and end of each frame and flags malformed frames. Its byte interface feeds the downstream byte-wide frame parser (header/FCS stage).

---
 rtl/tiny_eth_rx_deser_if.sv | 24 ++
 rtl/tiny_eth_rx_deser.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tiny_eth_rx_deser_if.sv
// Serial-line input and byte-stream output bundle of the tiny_eth receive deserializer.
// master drives the line (PHY side / bench), slave is the deserializer.
interface tiny_eth_rx_deser_if #(
    parameter int LEN_W = 11
);
    logic             serial_in;
    logic             rx_dv;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             sof;
    logic             eof;
    logic             err;
    logic [LEN_W-1:0] frame_len;

    modport master (
        output serial_in, rx_dv,
        input  byte_data, byte_valid, sof, eof, err, frame_len
    );

    modport slave (
        input  serial_in, rx_dv,
        output byte_data, byte_valid, sof, eof, err, frame_len
    );
endinterface

// File: rtl/tiny_eth_rx_deser.sv
// Receive deserializer: locks onto preamble+SFD, assembles LSB-first bytes,
// marks frame start/end and flags dribble, empty and oversize frames.
module tiny_eth_rx_deser #(
    parameter int MIN_PRE_BITS = 15,
    parameter int MAX_BYTES    = 1518,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input logic                rx_clk,
    input logic                rst,
    tiny_eth_rx_deser_if.slave rx
);
    localparam int ALT_W = $clog2(MIN_PRE_BITS + 1);
    localparam logic [ALT_W-1:0] MIN_L = ALT_W'(MIN_PRE_BITS);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_e;

    state_e           state_q, state_d;
    logic             prev_q, prev_d;
    logic [ALT_W-1:0] alt_q, alt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             bv_q, bv_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        alt_d   = alt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        len_d   = len_q;
        bv_d    = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx.rx_dv && rx.serial_in) begin
                    state_d = PREAMBLE;
                    alt_d   = ALT_W'(1);
                    prev_d  = 1'b1;
                end
            end
            PREAMBLE: begin
                if (!rx.rx_dv) begin
                    state_d = IDLE;
                end else if (rx.serial_in != prev_q) begin
                    alt_d  = (alt_q == MIN_L) ? alt_q : alt_q + 1'b1;
                    prev_d = rx.serial_in;
                end else if (rx.serial_in && alt_q >= MIN_L) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!rx.rx_dv) begin
                    // Leftover bits or no bytes at all make the frame malformed
                    state_d = IDLE;
                    eof_d   = 1'b1;
                    len_d   = cnt_q;
                    err_d   = (bit_q != 3'd0) || (cnt_q == '0);
                end else begin
                    shreg_d = {rx.serial_in, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (cnt_q < MAX_L) begin
                            data_d = {rx.serial_in, shreg_q[7:1]};
                            bv_d   = 1'b1;
                            sof_d  = (cnt_q == '0);
                            cnt_d  = cnt_q + 1'b1;
                            len_d  = cnt_q + 1'b1;
                        end else begin
                            // Oversize: report now, swallow the rest of the frame
                            state_d = DROP;
                            eof_d   = 1'b1;
                            err_d   = 1'b1;
                            len_d   = MAX_L;
                        end
                    end
                end
            end
            DROP: begin
                if (!rx.rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            alt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            cnt_q   <= '0;
            data_q  <= 8'd0;
            bv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            alt_q   <= alt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            bv_q    <= bv_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign rx.byte_data  = data_q;
    assign rx.byte_valid = bv_q;
    assign rx.sof        = sof_q;
    assign rx.eof        = eof_q;
    assign rx.err        = err_q;
    assign rx.frame_len  = len_q;
endmodule
